// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide HI/LO unit.
//   op_e     : opcode encodings carried on the Op field of the request bus
//   state_e  : sequencer states, also exported on the debug state port
//   DIV0_LO  : value written to LO when the divisor is zero (all ones)
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
    localparam logic [63:0] DIV0_LO = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Request/result bus between the EX-stage ALU (master) and the mul/div unit (slave).
//   Start, Op, X, Y, Flush : master -> unit
//   Busy, Done, HI, LO     : unit -> master
// Handshake: Start is a one-cycle request that is taken on a rising edge only
// while Busy=0 (Busy is the inverse of "ready"); a Start seen while Busy=1 is
// dropped, never queued. Done pulses for one cycle on the edge that retires a
// MULT*/DIV* result into HI/LO. Flush aborts any in-flight operation and also
// wins over a Start presented in the same cycle.
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, X, Y, Flush,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, X, Y, Flush,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// Iteration datapath for the mul/div unit, operating on unsigned magnitudes.
//   clk, rst_n : clock, async active-low reset
//   load       : initialise accumulator from a (multiplier / dividend)
//   step       : perform one shift-add (mult) or trial-subtract (div) iteration
//   is_div     : selects divide iteration
//   a, b       : a = multiplier/dividend (used on load), b = multiplicand/divisor (held)
//   prod       : 2*WIDTH product
//   quo, rem   : quotient and remainder
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem
);

    // Mult: acc = {partial product, unconsumed multiplier bits}.
    // Div : acc[WIDTH-1:0] = dividend bits shifting out / quotient bits shifting in.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   prem;

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           no_borrow;

    // The carry out of the add lands in the top bit as the whole word shifts right.
    assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    // Partial remainder is WIDTH+1 bits during the trial subtract; after the
    // step it is always below the divisor, so WIDTH bits suffice for storage.
    assign shifted   = {prem, acc[WIDTH-1]};
    assign trial     = shifted - {1'b0, b};
    assign no_borrow = ~trial[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            prem <= '0;
        end else if (load) begin
            acc  <= {{WIDTH{1'b0}}, a};
            prem <= '0;
        end else if (step) begin
            if (is_div) begin
                prem <= no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                acc  <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], no_borrow};
            end else begin
                acc  <= {add_sum, acc[WIDTH-1:1]};
            end
        end
    end

    assign prod = acc;
    assign quo  = acc[WIDTH-1:0];
    assign rem  = prem;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of muldiv_hilo_unit_if (Start/Op/X/Y/Flush in,
//                Busy/Done/HI/LO out)
//   dbg_state  : current sequencer state
// Timing: request accepted at edge E0; operand magnitudes latched. E1 loads the
// iteration core, E2..E(WIDTH+1) run WIDTH iterations, FIX retires into HI/LO
// and pulses Done on edge E(WIDTH+2), the same edge that drops Busy.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_hilo_unit_if.slave bus,
    output state_e            dbg_state
);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_q;    // product / quotient sign
    logic               neg_r;    // remainder sign (follows dividend)
    logic               is_div;
    logic               div0;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy;
    logic               done;

    op_e                op_in;
    logic               signed_op;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign op_in     = op_e'(bus.Op);
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state == S_CALC && cnt == '0),
        .step   (state == S_CALC && cnt != '0),
        .is_div (is_div),
        .a      (a_mag),
        .b      (b_mag),
        .prod   (prod),
        .quo    (quo),
        .rem    (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.Start && !bus.Flush) begin
                        case (op_in)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                a_mag  <= magnitude(bus.X, signed_op);
                                b_mag  <= magnitude(bus.Y, signed_op);
                                neg_q  <= signed_op & (bus.X[WIDTH-1] ^ bus.Y[WIDTH-1]);
                                neg_r  <= signed_op & bus.X[WIDTH-1];
                                is_div <= op_in[1];
                                div0   <= (bus.Y == '0);
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= S_CALC;
                            end
                            OP_MTHI: hi <= bus.X;
                            OP_MTLO: lo <= bus.X;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (bus.Flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // cnt==0 is the load cycle, so cnt==WIDTH is the last iteration.
                        if (cnt == CNT_W'(WIDTH)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!bus.Flush) begin
                        if (is_div) begin
                            // With a zero divisor the restoring loop leaves |X| as the
                            // remainder, so the sign fix already reproduces X in HI.
                            hi <= neg_r ? -rem : rem;
                            lo <= div0 ? DIV0_LO[WIDTH-1:0] : (neg_q ? -quo : quo);
                        end else begin
                            {hi, lo} <= neg_q ? -prod : prod;
                        end
                        done <= 1'b1;
                    end
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy  = busy;
    assign bus.Done  = done;
    assign bus.HI    = hi;
    assign bus.LO    = lo;
    assign dbg_state = state;

endmodule
